// File: rtl/vram_if.sv
// vram_if: the request/response handshakes for the display and GPU ports
// of the VRAM arbiter, plus the SRAM pin bundle on the far side.
// The slave modport is the arbiter's view; master is the requesters/pads view.
interface vram_if;
    logic        disp_req;
    logic [18:0] disp_addr;
    logic        disp_ack;
    logic [15:0] disp_rdata;
    logic        disp_rvalid;

    logic        gpu_req;
    logic        gpu_we;
    logic [18:0] gpu_addr;
    logic [15:0] gpu_wdata;
    logic        gpu_ack;
    logic [15:0] gpu_rdata;
    logic        gpu_rvalid;

    logic [19:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic        sram_lb_n;
    logic        sram_ub_n;

    modport slave (
        input  disp_req, disp_addr, gpu_req, gpu_we, gpu_addr, gpu_wdata, sram_dq_in,
        output disp_ack, disp_rdata, disp_rvalid, gpu_ack, gpu_rdata, gpu_rvalid,
        output sram_addr, sram_dq_out, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n
    );

    modport master (
        output disp_req, disp_addr, gpu_req, gpu_we, gpu_addr, gpu_wdata, sram_dq_in,
        input  disp_ack, disp_rdata, disp_rvalid, gpu_ack, gpu_rdata, gpu_rvalid,
        input  sram_addr, sram_dq_out, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n
    );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one 16-bit asynchronous SRAM between the display
// scan-out (read-only, fixed priority) and the GPU rasteriser (read/write).
// Every access takes ACCESS_CYCLES clocks in ACCESS followed by one IDLE
// turnaround cycle with all strobes released.
// Optional feature: define VRAM_STARVE_GUARD_EN to let the GPU through after
// DISP_BURST_MAX consecutive display grants made while it was waiting.
module vram_arbiter #(
    parameter int ACCESS_CYCLES  = 2,
    parameter int DISP_BURST_MAX = 8
) (
    input  logic   clk,
    input  logic   rst,
    vram_if.slave  bus
);
    localparam int CW = $clog2(ACCESS_CYCLES);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            owner_q, owner_d;
    logic            we_q, we_d;
    logic [18:0]     addr_q, addr_d;
    logic [15:0]     wdata_q, wdata_d;
    logic            ce_n_q, ce_n_d;
    logic            oe_n_q, oe_n_d;
    logic            we_n_q, we_n_d;
    logic [15:0]     disp_rdata_q, disp_rdata_d;
    logic [15:0]     gpu_rdata_q, gpu_rdata_d;
    logic            disp_rvalid_q, disp_rvalid_d;
    logic            gpu_rvalid_q, gpu_rvalid_d;
    logic            idle;
    logic            grant_disp;
    logic            grant_gpu;

    assign idle = (state_q == IDLE) && !rst;

`ifdef VRAM_STARVE_GUARD_EN
    localparam int SW = $clog2(DISP_BURST_MAX + 1);

    logic [SW-1:0] starve_q, starve_d;
    logic          force_gpu;

    assign force_gpu = (starve_q == SW'(DISP_BURST_MAX)) && bus.gpu_req;

    // Arbitration: display first, unless the GPU has waited through a full burst
    always_comb begin
        grant_gpu  = idle && bus.gpu_req && (!bus.disp_req || force_gpu);
        grant_disp = idle && bus.disp_req && !grant_gpu;
    end

    // Count display grants taken while the GPU was waiting; any GPU grant or an idle GPU clears it
    always_comb begin
        starve_d = starve_q;
        if (state_q == IDLE) begin
            if (grant_gpu || !bus.gpu_req) begin
                starve_d = '0;
            end else if (grant_disp && (starve_q != SW'(DISP_BURST_MAX))) begin
                starve_d = starve_q + SW'(1);
            end
        end
    end

    // Starvation counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    // Arbitration: strict display priority
    always_comb begin
        grant_disp = idle && bus.disp_req;
        grant_gpu  = idle && bus.gpu_req && !bus.disp_req;
    end
`endif

    // Next-state logic; strobes are derived from the next state so the pins come straight from flops
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        owner_d       = owner_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        disp_rdata_d  = disp_rdata_q;
        gpu_rdata_d   = gpu_rdata_q;
        disp_rvalid_d = 1'b0;
        gpu_rvalid_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_disp) begin
                    state_d = ACCESS;
                    cnt_d   = CW'(ACCESS_CYCLES - 1);
                    owner_d = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = bus.disp_addr;
                    wdata_d = 16'h0000;
                end else if (grant_gpu) begin
                    state_d = ACCESS;
                    cnt_d   = CW'(ACCESS_CYCLES - 1);
                    owner_d = 1'b1;
                    we_d    = bus.gpu_we;
                    addr_d  = bus.gpu_addr;
                    wdata_d = bus.gpu_wdata;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    if (!we_q) begin
                        if (owner_q) begin
                            gpu_rdata_d  = bus.sram_dq_in;
                            gpu_rvalid_d = 1'b1;
                        end else begin
                            disp_rdata_d  = bus.sram_dq_in;
                            disp_rvalid_d = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        ce_n_d = (state_d != ACCESS);
        oe_n_d = !((state_d == ACCESS) && !we_d);
        we_n_d = !((state_d == ACCESS) && we_d && (cnt_d != '0));
    end

    // State, latched request and registered SRAM strobes; reset abandons any access in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            owner_q       <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            ce_n_q        <= 1'b1;
            oe_n_q        <= 1'b1;
            we_n_q        <= 1'b1;
            disp_rdata_q  <= '0;
            gpu_rdata_q   <= '0;
            disp_rvalid_q <= 1'b0;
            gpu_rvalid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            owner_q       <= owner_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            ce_n_q        <= ce_n_d;
            oe_n_q        <= oe_n_d;
            we_n_q        <= we_n_d;
            disp_rdata_q  <= disp_rdata_d;
            gpu_rdata_q   <= gpu_rdata_d;
            disp_rvalid_q <= disp_rvalid_d;
            gpu_rvalid_q  <= gpu_rvalid_d;
        end
    end

    assign bus.disp_ack    = grant_disp;
    assign bus.gpu_ack     = grant_gpu;
    assign bus.disp_rdata  = disp_rdata_q;
    assign bus.disp_rvalid = disp_rvalid_q;
    assign bus.gpu_rdata   = gpu_rdata_q;
    assign bus.gpu_rvalid  = gpu_rvalid_q;
    assign bus.sram_addr   = {1'b0, addr_q};
    assign bus.sram_dq_out = wdata_q;
    assign bus.sram_ce_n   = ce_n_q;
    assign bus.sram_oe_n   = oe_n_q;
    assign bus.sram_we_n   = we_n_q;
    assign bus.sram_lb_n   = ce_n_q;
    assign bus.sram_ub_n   = ce_n_q;
endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single 16-bit asynchronous SRAM (VRAM) between two requesters: the display scan-out path (read-only) and the GPU rasteriser (read/write).
- Fixed priority goes to display, which is deadline-bound.
- Each access is a multi-cycle SRAM cycle. Control strobes and write data are registered.
- Sits between the display controller, the GPU and the top-level SRAM pins, replacing ad-hoc VRAM muxing.

Parameters:
- ACCESS_CYCLES, 2: clocks per SRAM access; legal range ≥2.
- DISP_BURST_MAX, 8: consecutive display grants allowed while a GPU request is pending (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- disp_req  in  1  display read request; held until disp_ack
- disp_addr  in  19  display word address
- disp_ack  out  1  request accepted (one-cycle pulse)
- disp_rdata  out  16  read data
- disp_rvalid  out  1  disp_rdata valid (one-cycle pulse)
- gpu_req  in  1  GPU request; held until gpu_ack
- gpu_we  in  1  1 = write, 0 = read
- gpu_addr  in  19  GPU word address
- gpu_wdata  in  16  write data
- gpu_ack  out  1  request accepted (one-cycle pulse)
- gpu_rdata  out  16  read data
- gpu_rvalid  out  1  gpu_rdata valid (one-cycle pulse)
- sram_addr  out  20  {1'b0, latched addr}
- sram_dq_out  out  16  write data to pad tristate
- sram_dq_in  in  16  data from pad
- sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n  out  1 each  active-low SRAM strobes

Behaviour:
- States: IDLE and ACCESS. An internal counter cnt counts down ACCESS_CYCLES-1..0.
- Reset (sync, rst high at a clk edge):
  - state = IDLE.
  - ce_n, oe_n, we_n, lb_n, ub_n = 1.
  - sram_addr = 0, sram_dq_out = 0.
  - acks and rvalids = 0, rdata = 0.
  - Starvation counter = 0.
- Reset mid-access abandons the access: no rvalid is issued and we_n deasserts on the same edge.
- IDLE, arbitration:
  - Display wins if disp_req is high; otherwise GPU wins if gpu_req is high.
  - The winning ack is combinational and asserts in this IDLE cycle. Only one ack is high per cycle.
  - On the edge, latch addr, we (display is always a read), wdata and the owner ID.
  - Go to ACCESS with cnt = ACCESS_CYCLES-1.
- ACCESS:
  - ce_n = 0, lb_n = 0, ub_n = 0, sram_addr stable.
  - Read: oe_n = 0 for all ACCESS_CYCLES cycles.
  - Write: oe_n = 1. we_n = 0 while cnt ≠ 0 and 1 in the last cycle, which gives address/data hold. sram_dq_out = latched wdata for the whole access.
  - cnt == 0: on the edge, capture sram_dq_in into the owner's rdata (reads only) and return to IDLE.
- rvalid:
  - Registered; pulses in the cycle after the last ACCESS cycle, i.e. ACCESS_CYCLES+1 cycles after ack.
  - Writes produce no rvalid.
  - rdata holds its value until the next read for that owner.
- IDLE as turnaround: all strobes are deasserted in IDLE.
  - Peak throughput is one access per ACCESS_CYCLES+1 clocks.
  - An rvalid and a new ack may coincide.
- A requester dropping req before ack is legal; nothing is issued.
- Address or data changes after ack do not affect the in-flight access.
- A simultaneous disp_req and gpu_req goes to display; the GPU waits, with req held.

Optional Feature:
- Macro: VRAM_STARVE_GUARD_EN.
- With the macro:
  - The 4-bit-wide-enough counter (sized $clog2(DISP_BURST_MAX+1)) increments on each display grant made while gpu_req is high.
  - It clears on any GPU grant, or when gpu_req is low in IDLE.
  - When the counter == DISP_BURST_MAX and gpu_req is high, the next IDLE grants the GPU even if disp_req is high.
- Without the macro: strict display priority, and no counter logic is generated.

Test Plan:
- Single display read (ACCESS_CYCLES=2, disp_addr=19'h00123, SRAM model returns 16'hBEEF):
  - disp_ack in cycle T.
  - ce_n=0 and oe_n=0 in T+1..T+2, sram_addr=20'h00123.
  - disp_rvalid=1 in T+3 with disp_rdata=16'hBEEF.
- GPU write (gpu_addr=19'h7FFFF, wdata=16'h1234):
  - gpu_ack in T.
  - we_n=0 only in T+1 and we_n=1 in T+2.
  - sram_dq_out=16'h1234 in T+1..T+2.
  - No gpu_rvalid; the model holds 16'h1234 at 20'h7FFFF.
- Simultaneous requests:
  - disp_req and gpu_req (read) both high in the same IDLE cycle.
  - disp_ack is granted first; gpu_ack follows 3 cycles later.
  - Both rvalids return the correct data in order.
- Starvation, with VRAM_STARVE_GUARD_EN and DISP_BURST_MAX=8:
  - Hold disp_req and gpu_req high continuously.
  - Pattern is 8 display grants, 1 GPU grant, repeating.
  - Without the macro, the GPU is never granted.
- Reset mid-write:
  - Assert rst in T+1 of a GPU write.
  - Next edge: all strobes high, no rvalid, state IDLE.
  - A following display read completes normally.
- Back-to-back display reads (disp_req held, addresses incrementing):
  - ack every 3 cycles.
  - rvalid coincides with the next ack.
  - Data matches the model for 16 consecutive addresses.
